instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Writer side of the instruction memory: receives a byte stream (e.g. from UART RX), packs byte pairs
//  into 16-bit instructions, writes them to consecutive instruction-memory addresses.
//  Holds the CPU off (cpu_hold) while loading; reports done or timeout error.
//  Sits between the host byte link and the instruction memory write port.
// PARAMETERS
//  ADDR_W   10    instruction memory address width (word addressed)
//  DATA_W   16    instruction width; fixed at 2 bytes
//  TIMEOUT  1024  max consecutive cycles waiting for a byte in LOAD_HI/LOAD_LO before abort
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         begin load; sampled only in IDLE
//  base_addr  in   ADDR_W    first word address; latched on accepted start
//  word_cnt   in   ADDR_W+1  number of words to load; latched on accepted start
//  byte_vld   in   1         byte_in valid
//  byte_in    in   8         stream byte
//  byte_rdy   out  1         loader can accept byte this cycle
//  mem_wr_en  out  1         one-cycle write strobe to instruction memory
//  mem_addr   out  ADDR_W    write address
//  mem_wdata  out  DATA_W    write data
//  busy       out  1         load in progress
//  cpu_hold   out  1         equals busy; keeps CPU fetch stalled
//  done       out  1         one-cycle pulse on successful completion
//  err        out  1         timeout abort flag; sticky until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; index, timeout counter, latched base/count cleared.
//   Memory contents already written are not touched.
//  All outputs registered. Byte transfer occurs on posedge where byte_vld & byte_rdy.
//  States:
//   IDLE: byte_rdy=0, busy=0. start=1 -> latch base_addr/word_cnt, idx=0, err<=0;
//     word_cnt==0 -> DONE, else -> LOAD_HI. start outside IDLE is ignored.
//   LOAD_HI: byte_rdy=1, busy=1. Transfer -> hi<=byte_in, -> LOAD_LO.
//   LOAD_LO: byte_rdy=1. Transfer -> mem_wdata<={hi,byte_in}, mem_addr<=base+idx, -> WRITE.
//   WRITE: mem_wr_en=1 for exactly this one cycle, byte_rdy=0. idx<=idx+1;
//     idx+1==count -> DONE, else -> LOAD_HI.
//   DONE: done=1 for one cycle, busy=1; -> IDLE (busy=0 next cycle).
//   ERR: entered from LOAD_HI/LOAD_LO when timeout counter reaches TIMEOUT; err<=1, no write of
//     partial word; -> IDLE next cycle. done not asserted on abort.
//  Byte order: first byte of each pair is instr[15:8], second is instr[7:0].
//  Timeout counter: clears on every transfer and on entry to LOAD_HI; counts each LOAD_HI/LOAD_LO
//   cycle without transfer; abort on the cycle count==TIMEOUT.
//  Address arithmetic: base+idx modulo 2^ADDR_W (wraps 0x3FF -> 0x000 at default).
//  word_cnt max 2^ADDR_W; larger values saturate to 2^ADDR_W.
//  Throughput: 3 cycles/word minimum (LOAD_HI, LOAD_LO, WRITE); byte_vld gaps just extend states.
//  Memory reads the write port on its own edge; mem_addr/mem_wdata stable whenever mem_wr_en=1.
//  Reset mid-load: immediate return to IDLE, cpu_hold/byte_rdy drop asynchronously, no done/err.
// TESTING
//  1 start, base=0x010, cnt=3, bytes 12 34 AB CD 00 01 back-to-back -> writes 0x010=1234,
//    0x011=ABCD, 0x012=0001, one mem_wr_en per word, single done pulse, busy low after.
//  2 cnt=0 -> DONE next cycle, done one pulse, no mem_wr_en, byte_rdy never high.
//  3 base=0x3FF, cnt=2, bytes 11 22 33 44 -> 0x3FF=1122, 0x000=3344 (wrap).
//  4 TIMEOUT=16, cnt=2, send 5A then stall -> err=1 after 16 idle cycles, no write, done=0;
//    next start clears err.
//  5 random byte_vld gaps plus start pulses while busy -> same data as gap-free run, starts ignored.
//  6 rst asserted after first word written -> outputs 0 immediately, word 0 kept, new load works.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction-memory loader: packs a byte stream into 16-bit words and writes them to
// consecutive addresses, holding the CPU off until the load completes or times out.
module instr_loader #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic              byte_vld,
    input  logic [7:0]        byte_in,
    output logic              byte_rdy,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);
    // Byte handshake: a byte moves on the posedge where byte_vld and byte_rdy are both high.
    // byte_rdy is a flop, so the sender sees it for the whole cycle before that edge.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [TW-1:0]   TMO_ONE   = TW'(1);
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_LOAD_LO = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t            state, state_d;
    logic [TW-1:0]     tmo_cnt, tmo_d;
    logic [ADDR_W:0]   idx, idx_inc, count;
    logic [ADDR_W-1:0] base;
    logic [7:0]        hi;
    logic              xfer, load_d;

    assign dbg_state = state;

    always_comb begin
        state_d = state;
        tmo_d   = tmo_cnt;
        xfer    = byte_vld & byte_rdy;
        idx_inc = idx + IDX_ONE;
        case (state)
            S_IDLE: begin
                tmo_d = '0;
                if (start) state_d = (word_cnt == '0) ? S_DONE : S_LOAD_HI;
            end
            S_LOAD_HI, S_LOAD_LO: begin
                if (xfer) begin
                    tmo_d   = '0;
                    state_d = (state == S_LOAD_HI) ? S_LOAD_LO : S_WRITE;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_cnt + TMO_ONE;
                end
            end
            S_WRITE: begin
                tmo_d   = '0;
                state_d = (idx_inc == count) ? S_DONE : S_LOAD_HI;
            end
            default: begin
                tmo_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        load_d = (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            idx       <= '0;
            count     <= '0;
            base      <= '0;
            hi        <= '0;
            byte_rdy  <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            tmo_cnt <= tmo_d;
            if (state == S_IDLE && start) begin
                base  <= base_addr;
                count <= (word_cnt > MAX_WORDS) ? MAX_WORDS : word_cnt;
                idx   <= '0;
                err   <= 1'b0;
            end
            if (state == S_LOAD_HI && xfer) hi <= byte_in;
            if (state == S_LOAD_LO && xfer) begin
                mem_wdata <= {hi, byte_in};
                mem_addr  <= base + idx[ADDR_W-1:0];
            end
            if (state == S_WRITE) idx <= idx_inc;
            if (state_d == S_ERR) err <= 1'b1;
            // Ready is withheld on the abort cycle so no byte is taken and then discarded.
            byte_rdy  <= load_d && (tmo_d != TMO_LIMIT);
            mem_wr_en <= (state_d == S_WRITE);
            done      <= (state_d == S_DONE);
            busy      <= (state_d != S_IDLE);
            cpu_hold  <= (state_d != S_IDLE);
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized byte streams against a word-level model.
module tb_instr_loader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int TMO    = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_cnt = '0;
    logic              byte_vld = 1'b0;
    logic [7:0]        byte_in = '0;
    logic              byte_rdy, mem_wr_en, busy, cpu_hold, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
        .byte_vld(byte_vld), .byte_in(byte_in), .byte_rdy(byte_rdy), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .cpu_hold(cpu_hold),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [25:0] exp_q[$];
    logic [25:0] wr_q[$];
    int          wr_cyc[$];
    logic [7:0]  tx_bytes[$];
    logic [15:0] mem_img [DEPTH];
    int cyc = 0, done_cnt = 0, rdy_cnt = 0, hold_bad = 0;
    bit spam_en = 1'b0;

    always @(posedge clk) cyc++;

    // Write-port monitor: an instruction memory model plus event counters.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            wr_q.push_back({mem_addr, mem_wdata});
            wr_cyc.push_back(cyc);
            mem_img[mem_addr] = mem_wdata;
        end
        if (done === 1'b1) done_cnt++;
        if (byte_rdy === 1'b1) rdy_cnt++;
        if (busy !== cpu_hold) hold_bad++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic fill_bytes(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: word i = {byte 2i, byte 2i+1} at (base + i) mod 2^ADDR_W.
    task automatic model_load(input logic [ADDR_W-1:0] base, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            int a;
            a = (int'(base) + i) % DEPTH;
            exp_q.push_back({ADDR_W'(a), tx_bytes[2*i], tx_bytes[2*i+1]});
        end
    endtask

    task automatic start_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt);
        base_addr = base;
        word_cnt  = cnt;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic spam_start();
        start     = 1'($urandom_range(0, 1));
        base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        word_cnt  = (ADDR_W+1)'($urandom_range(0, 2 * DEPTH - 1));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int t = 0;
        byte_vld = 1'b0;
        repeat (gap) begin
            if (spam_en) spam_start();
            @(negedge clk);
        end
        byte_vld = 1'b1;
        byte_in  = b;
        while (byte_rdy !== 1'b1 && t < 100) begin
            if (spam_en) spam_start();
            @(negedge clk);
            t++;
        end
        ok = (byte_rdy === 1'b1);
        @(negedge clk);
        byte_vld = 1'b0;
    endtask

    task automatic send_all(input int max_gap, output int misses);
        bit ok;
        misses = 0;
        foreach (tx_bytes[i]) begin
            send_byte(tx_bytes[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)), ok);
            if (!ok) misses++;
        end
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #13;
        checks++;
        if ({byte_rdy, mem_wr_en, busy, cpu_hold, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {byte_rdy, mem_wr_en, busy, cpu_hold, done, err});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h data=%h want 0/0", mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_rdy, mem_wr_en, busy, cpu_hold, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle got %b want 000000", {byte_rdy, mem_wr_en, busy, cpu_hold, done, err});
        end
    endtask

    task automatic test_basic();
        int miss, lat, d0;
        logic [25:0] e, g;
        tx_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
        exp_q    = '{{10'h010, 16'h1234}, {10'h011, 16'hABCD}, {10'h012, 16'h0001}};
        wr_q.delete();
        wr_cyc.delete();
        d0 = done_cnt;
        start_load(10'h010, 11'd3);
        send_all(0, miss);
        wait_done(lat);
        checks++;
        if (lat < 0 || miss != 0) begin
            errors++;
            $display("FAIL basic_handshake got lat=%0d miss=%0d want done and 0 misses", lat, miss);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0);
        end
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after got busy=%b hold=%b done=%b want 0 0 0", busy, cpu_hold, done);
        end
        checks++;
        if (wr_cyc.size() != 3) begin
            errors++;
            $display("FAIL basic_write_count got %0d want 3", wr_cyc.size());
        end else begin
            checks++;
            if (wr_cyc[1] - wr_cyc[0] != 3 || wr_cyc[2] - wr_cyc[1] != 3) begin
                errors++;
                $display("FAIL basic_throughput got gaps %0d %0d want 3 3",
                         wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
            end
        end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front();
            g = wr_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL basic_write got %h want %h", g, e);
            end
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic test_zero_count();
        int d0, r0;
        d0 = done_cnt;
        r0 = rdy_cnt;
        wr_q.delete();
        start_load(ADDR_W'($urandom_range(0, DEPTH - 1)), 11'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done got done=%b busy=%b want 1 1", done, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1 || rdy_cnt != r0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL zero_side got dones=%0d rdy=%0d writes=%0d want 1 0 0",
                     done_cnt - d0, rdy_cnt - r0, wr_q.size());
        end
    endtask

    task automatic test_wrap();
        int miss, lat;
        logic [25:0] e, g;
        tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q    = '{{10'h3FF, 16'h1122}, {10'h000, 16'h3344}};
        wr_q.delete();
        start_load(10'h3FF, 11'd2);
        send_all(0, miss);
        wait_done(lat);
        checks++;
        if (lat < 0 || miss != 0 || wr_q.size() != 2) begin
            errors++;
            $display("FAIL wrap_flow got lat=%0d miss=%0d writes=%0d want done 0 2", lat, miss, wr_q.size());
        end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front();
            g = wr_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL wrap_write got %h want %h", g, e);
            end
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic test_timeout();
        int miss, lat, d0, t;
        logic [ADDR_W-1:0] b2;
        logic [25:0] e, g;
        d0 = done_cnt;
        wr_q.delete();
        tx_bytes = '{8'h5A};
        start_load(ADDR_W'($urandom_range(0, DEPTH - 1)), 11'd2);
        send_all(0, miss);
        t = 0;
        while (err !== 1'b1 && t < 4 * TMO) begin
            @(negedge clk);
            t++;
        end
        // Counter reaches TIMEOUT after TIMEOUT idle cycles; abort lands on the next one.
        checks++;
        if (t < TMO || t > TMO + 1) begin
            errors++;
            $display("FAIL timeout_latency got %0d want %0d..%0d", t, TMO, TMO + 1);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || byte_rdy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky got err=%b busy=%b rdy=%b want 1 0 0", err, busy, byte_rdy);
        end
        checks++;
        if (wr_q.size() != 0 || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_side got writes=%0d dones=%0d want 0 0", wr_q.size(), done_cnt - d0);
        end
        fill_bytes(2);
        b2 = ADDR_W'($urandom_range(0, DEPTH - 1));
        model_load(b2, 1);
        start_load(b2, 11'd1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear got err=%b want 0", err);
        end
        send_all(0, miss);
        wait_done(lat);
        checks++;
        if (lat < 0 || wr_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_recover got lat=%0d writes=%0d want done 1", lat, wr_q.size());
        end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front();
            g = wr_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL timeout_write got %h want %h", g, e);
            end
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic test_random_gaps();
        int miss, lat, d0, n;
        logic [ADDR_W-1:0] b;
        logic [25:0] e, g;
        spam_en = 1'b1;
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 8));
            b = ADDR_W'($urandom_range(0, DEPTH - 1));
            fill_bytes(2 * n);
            model_load(b, n);
            wr_q.delete();
            d0 = done_cnt;
            start_load(b, (ADDR_W+1)'(n));
            send_all(5, miss);
            wait_done(lat);
            repeat (3) @(negedge clk);
            #1;
            checks++;
            if (lat < 0 || miss != 0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL gaps_flow got lat=%0d miss=%0d dones=%0d busy=%b want done 0 1 0",
                         lat, miss, done_cnt - d0, busy);
            end
            checks++;
            if (wr_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL gaps_count got %0d want %0d", wr_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && wr_q.size() > 0) begin
                e = exp_q.pop_front();
                g = wr_q.pop_front();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL gaps_write got %h want %h", g, e);
                end
            end
            exp_q.delete();
            wr_q.delete();
        end
        spam_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int miss, lat, d0, n;
        logic [ADDR_W-1:0] b;
        logic [25:0] e, g;
        wr_q.delete();
        d0 = done_cnt;
        for (int it = 0; it < 2; it++) begin
            n = int'($urandom_range(2, 5));
            b = ADDR_W'($urandom_range(0, DEPTH - 1));
            fill_bytes(2 * n);
            model_load(b, n);
            start_load(b, (ADDR_W+1)'(n));
            send_all(0, miss);
            wait_done(lat);
            checks++;
            if (lat < 0 || miss != 0) begin
                errors++;
                $display("FAIL b2b_flow got lat=%0d miss=%0d want done 0", lat, miss);
            end
        end
        checks++;
        if (done_cnt - d0 != 2 || wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got dones=%0d writes=%0d want 2 %0d", done_cnt - d0, wr_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front();
            g = wr_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_write got %h want %h", g, e);
            end
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic test_saturate();
        int miss, lat, bad;
        logic [25:0] e, g;
        bad = 0;
        fill_bytes(2 * DEPTH);
        model_load(10'h200, DEPTH);
        wr_q.delete();
        start_load(10'h200, 11'h7FF);
        send_all(0, miss);
        wait_done(lat);
        checks++;
        if (lat < 0 || miss != 0 || wr_q.size() != DEPTH) begin
            errors++;
            $display("FAIL sat_flow got lat=%0d miss=%0d writes=%0d want done 0 %0d", lat, miss, wr_q.size(), DEPTH);
        end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front();
            g = wr_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                if (bad < 8) $display("FAIL sat_write got %h want %h", g, e);
                bad++;
            end
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic test_reset_mid_load();
        int miss, lat, d0;
        bit ok;
        logic [ADDR_W-1:0] b, b2;
        logic [25:0] e, g;
        b = ADDR_W'($urandom_range(0, DEPTH - 1));
        fill_bytes(6);
        wr_q.delete();
        d0 = done_cnt;
        start_load(b, 11'd3);
        send_byte(tx_bytes[0], 0, ok);
        send_byte(tx_bytes[1], 0, ok);
        @(negedge clk);
        #1;
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {b, tx_bytes[0], tx_bytes[1]}) begin
            errors++;
            $display("FAIL midrst_word0 got n=%0d val=%h want 1 %h", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : 26'h0, {b, tx_bytes[0], tx_bytes[1]});
        end
        send_byte(tx_bytes[2], 0, ok);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({byte_rdy, cpu_hold, busy, done, err, mem_wr_en} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_async got %b want 000000", {byte_rdy, cpu_hold, busy, done, err, mem_wr_en});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (mem_img[b] !== {tx_bytes[0], tx_bytes[1]} || wr_q.size() != 1 || done_cnt != d0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_kept got mem=%h writes=%0d dones=%0d err=%b want %h 1 0 0",
                     mem_img[b], wr_q.size(), done_cnt - d0, err, {tx_bytes[0], tx_bytes[1]});
        end
        wr_q.delete();
        b2 = ADDR_W'($urandom_range(0, DEPTH - 1));
        fill_bytes(4);
        model_load(b2, 2);
        start_load(b2, 11'd2);
        send_all(0, miss);
        wait_done(lat);
        checks++;
        if (lat < 0 || miss != 0 || wr_q.size() != 2) begin
            errors++;
            $display("FAIL midrst_reload got lat=%0d miss=%0d writes=%0d want done 0 2", lat, miss, wr_q.size());
        end
        while (exp_q.size() > 0 && wr_q.size() > 0) begin
            e = exp_q.pop_front();
            g = wr_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL midrst_write got %h want %h", g, e);
            end
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_timeout();
        test_random_gaps();
        test_back_to_back();
        test_saturate();
        test_reset_mid_load();
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL hold_equals_busy got %0d differing cycles want 0", hold_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
